// File: rtl/instr_fetch_unit_pkg.sv
// rtl/instr_fetch_unit_pkg.sv - shared widths, constants and FSM encoding for the instruction fetch unit
package instr_fetch_unit_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_WORD     = 32'h0000_0000;
  localparam logic [ADDR_W-1:0]  RESET_VECTOR = 16'h0000;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_KILL = 2'd3
  } ifu_state_e;

  // Modulo 2^16 increment; wraps 0xFFFF to 0x0000 with no carry out.
  function automatic logic [ADDR_W-1:0] pc_incr(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/ifu_skid_reg.sv
// rtl/ifu_skid_reg.sv - one-entry skid holding the word that was in flight when decode stalled
module ifu_skid_reg
  import instr_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_word,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic               i_valid,
  output logic [INSTR_W-1:0] o_word,
  output logic [ADDR_W-1:0]  o_addr,
  output logic               o_valid
);

  logic [INSTR_W-1:0] r_word;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_valid;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word <= NOP_WORD;
      r_addr <= RESET_VECTOR;
    end else if (i_load) begin
      r_word <= i_word;
      r_addr <= i_addr;
    end
  end

  assign o_word  = r_word;
  assign o_addr  = r_addr;
  assign o_valid = r_valid;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, fetch FSM and instruction register; IFU_REDIRECT_COUNT_EN adds redirect_count
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  jmp_loc,
  input  logic               pc_mux_sel,
  input  logic               stall,
  output logic [ADDR_W-1:0]  pm_addr,
  input  logic [INSTR_W-1:0] pm_data,
  output logic [INSTR_W-1:0] ins,
  output logic [ADDR_W-1:0]  current_address,
  output logic               ins_valid
`ifdef IFU_REDIRECT_COUNT_EN
  ,
  output logic [15:0]        redirect_count
`endif
);

  ifu_state_e         r_state,      w_state_nxt;
  logic [ADDR_W-1:0]  r_pc,         w_pc_nxt;
  logic [ADDR_W-1:0]  r_fetch_addr, w_fetch_addr_nxt;
  logic               r_req,        w_req_nxt;
  logic [INSTR_W-1:0] r_ins,        w_ins_nxt;
  logic [ADDR_W-1:0]  r_cur_addr,   w_cur_addr_nxt;
  logic               r_ins_valid,  w_ins_valid_nxt;

  logic               w_skid_load;
  logic               w_skid_clear;
  logic [INSTR_W-1:0] w_skid_word;
  logic [ADDR_W-1:0]  w_skid_addr;
  logic               w_skid_valid;

  ifu_skid_reg u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_word  (pm_data),
    .i_addr  (r_fetch_addr),
    .i_valid (r_req),
    .o_word  (w_skid_word),
    .o_addr  (w_skid_addr),
    .o_valid (w_skid_valid)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_fetch_addr_nxt = r_fetch_addr;
    w_req_nxt        = r_req;
    w_ins_nxt        = r_ins;
    w_cur_addr_nxt   = r_cur_addr;
    w_ins_valid_nxt  = r_ins_valid;
    w_skid_load      = 1'b0;
    w_skid_clear     = 1'b0;

    if (pc_mux_sel) begin
      // Redirect beats stall; a word returning during KILL is still stale.
      w_pc_nxt         = jmp_loc;
      w_fetch_addr_nxt = r_pc;
      w_req_nxt        = 1'b1;
      w_ins_nxt        = pm_data;
      w_cur_addr_nxt   = r_fetch_addr;
      w_ins_valid_nxt  = r_req && (r_state != ST_KILL);
      w_skid_clear     = 1'b1;
      w_state_nxt      = ST_KILL;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (stall) begin
            w_skid_load      = 1'b1;
            w_fetch_addr_nxt = r_pc;
            w_req_nxt        = 1'b1;
            w_state_nxt      = ST_HOLD;
          end else begin
            w_pc_nxt         = pc_incr(r_pc);
            w_fetch_addr_nxt = r_pc;
            w_req_nxt        = 1'b1;
            w_ins_nxt        = pm_data;
            w_cur_addr_nxt   = r_fetch_addr;
            w_ins_valid_nxt  = r_req;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            // pm_data here repeats the re-issued fetch and is dropped.
            w_ins_nxt        = w_skid_word;
            w_cur_addr_nxt   = w_skid_addr;
            w_ins_valid_nxt  = w_skid_valid;
            w_pc_nxt         = pc_incr(r_pc);
            w_fetch_addr_nxt = r_pc;
            w_req_nxt        = 1'b1;
            w_skid_clear     = 1'b1;
            w_state_nxt      = ST_RUN;
          end
        end
        ST_KILL: begin
          w_pc_nxt         = pc_incr(r_pc);
          w_fetch_addr_nxt = r_pc;
          w_req_nxt        = 1'b1;
          w_ins_nxt        = pm_data;
          w_cur_addr_nxt   = r_fetch_addr;
          w_ins_valid_nxt  = 1'b0;
          w_state_nxt      = ST_RUN;
        end
        default: begin
          w_pc_nxt         = pc_incr(r_pc);
          w_fetch_addr_nxt = r_pc;
          w_req_nxt        = 1'b1;
          w_ins_nxt        = pm_data;
          w_cur_addr_nxt   = r_fetch_addr;
          w_ins_valid_nxt  = 1'b0;
          w_state_nxt      = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_BOOT;
      r_pc         <= RESET_VECTOR;
      r_fetch_addr <= RESET_VECTOR;
      r_req        <= 1'b0;
      r_ins        <= NOP_WORD;
      r_cur_addr   <= RESET_VECTOR;
      r_ins_valid  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_req        <= w_req_nxt;
      r_ins        <= w_ins_nxt;
      r_cur_addr   <= w_cur_addr_nxt;
      r_ins_valid  <= w_ins_valid_nxt;
    end
  end

  assign pm_addr         = r_pc;
  assign ins             = r_ins;
  assign current_address = r_cur_addr;
  assign ins_valid       = r_ins_valid;

`ifdef IFU_REDIRECT_COUNT_EN
  logic [15:0] r_redirect_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_count <= 16'h0000;
    end else if (pc_mux_sel) begin
      r_redirect_count <= r_redirect_count + 16'd1;
    end
  end

  assign redirect_count = r_redirect_count;
`endif

endmodule
